// File: rtl/ppc_config_controller_pkg.sv
// Shared definitions for the ping-pong counter configuration controller:
// FSM state encoding, bound reset defaults and the default value width.
package ppc_config_controller_pkg;

    localparam int VAL_W_DEF = 4;
    localparam int MAX_RST   = 15;
    localparam int MIN_RST   = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EDIT_MAX = 2'd1,
        EDIT_MIN = 2'd2,
        COMMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/ppc_config_controller_if.sv
// Front-panel bus: raw buttons in, committed bounds and display/debug signals out.
// master = controller side, slave = board/counter side.
interface ppc_config_controller_if
    import ppc_config_controller_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF
);
    logic             btn_mode;
    logic             btn_up;
    logic             btn_down;
    logic [VAL_W-1:0] cnt_max;
    logic [VAL_W-1:0] cnt_min;
    logic             cnt_enable;
    logic             cnt_rst_n;
    logic [VAL_W-1:0] edit_val;
    logic [1:0]       state;
    logic             cfg_error;

    modport master (
        input  btn_mode,
        input  btn_up,
        input  btn_down,
        output cnt_max,
        output cnt_min,
        output cnt_enable,
        output cnt_rst_n,
        output edit_val,
        output state,
        output cfg_error
    );

    modport slave (
        output btn_mode,
        output btn_up,
        output btn_down,
        input  cnt_max,
        input  cnt_min,
        input  cnt_enable,
        input  cnt_rst_n,
        input  edit_val,
        input  state,
        input  cfg_error
    );

endinterface

// File: rtl/ppc_config_controller_btn_conditioner.sv
// Push-button conditioner: tick-sampled debounce shift register followed by a
// registered one-cycle press pulse on the rising edge of the debounced level.
module btn_conditioner
    import ppc_config_controller_pkg::*;
#(
    parameter int DEB_LEN = 4
) (
    input  logic clk_origin,
    input  logic rst_n,
    input  logic tick_en,
    input  logic btn,
    output logic press
);

    logic [DEB_LEN-1:0] sh_p0;
    logic               deb_p1;
    logic               debounced;

    assign debounced = &sh_p0;

    always_ff @(posedge clk_origin or negedge rst_n) begin
        if (!rst_n) begin
            sh_p0  <= '0;
            deb_p1 <= 1'b0;
            press  <= 1'b0;
        end else begin
            // stage p0: sample the raw button once per tick
            if (tick_en) begin
                sh_p0 <= {sh_p0[DEB_LEN-2:0], btn};
            end
            // stage p1: remember the previous debounced level
            deb_p1 <= debounced;
            // stage p2: one pulse per press; release re-arms via deb_p1 falling
            press  <= debounced & ~deb_p1;
        end
    end

endmodule

// File: rtl/ppc_config_controller.sv
// Configuration controller: tick generator, three button conditioners and the
// edit FSM that validates and commits new max/min bounds to the counter.
module ppc_config_controller
    import ppc_config_controller_pkg::*;
#(
    parameter int TICK_W  = 16,
    parameter int DEB_LEN = 4,
    parameter int VAL_W   = VAL_W_DEF
) (
    input  logic                     clk_origin,
    input  logic                     rst_n,
    ppc_config_controller_if.master  bus
);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_en;
    logic              mode_press;
    logic              up_press;
    logic              down_press;

    state_t            cur_state;
    logic [VAL_W-1:0]  shadow_max;
    logic [VAL_W-1:0]  shadow_min;
    logic [VAL_W-1:0]  max_val;
    logic [VAL_W-1:0]  min_val;
    logic              enable_reg;
    logic              reload_n;
    logic              error_flag;

    function automatic logic [VAL_W-1:0] sat_step(
        input logic [VAL_W-1:0] val,
        input logic             inc,
        input logic             dec
    );
        logic [VAL_W-1:0] res;
        res = val;
        if (inc && !dec && (val != {VAL_W{1'b1}})) begin
            res = val + VAL_W'(1);
        end else if (dec && !inc && (val != '0)) begin
            res = val - VAL_W'(1);
        end
        return res;
    endfunction

    always_ff @(posedge clk_origin or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick_en = &tick_cnt;

    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_mode (
        .clk_origin (clk_origin),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .btn        (bus.btn_mode),
        .press      (mode_press)
    );

    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_up (
        .clk_origin (clk_origin),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .btn        (bus.btn_up),
        .press      (up_press)
    );

    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_down (
        .clk_origin (clk_origin),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .btn        (bus.btn_down),
        .press      (down_press)
    );

    always_ff @(posedge clk_origin or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= RUN;
            max_val    <= VAL_W'(MAX_RST);
            min_val    <= VAL_W'(MIN_RST);
            shadow_max <= VAL_W'(MAX_RST);
            shadow_min <= VAL_W'(MIN_RST);
            enable_reg <= 1'b1;
            reload_n   <= 1'b1;
            error_flag <= 1'b0;
        end else begin
            reload_n <= 1'b1;
            case (cur_state)
                RUN: begin
                    if (mode_press) begin
                        cur_state  <= EDIT_MAX;
                        shadow_max <= max_val;
                        shadow_min <= min_val;
                        enable_reg <= 1'b0;
                        error_flag <= 1'b0;
                    end
                end
                EDIT_MAX: begin
                    // mode has priority; a simultaneous up/down is dropped
                    if (mode_press) begin
                        cur_state  <= EDIT_MIN;
                        error_flag <= 1'b0;
                    end else begin
                        shadow_max <= sat_step(shadow_max, up_press, down_press);
                    end
                end
                EDIT_MIN: begin
                    if (mode_press) begin
                        cur_state  <= COMMIT;
                        error_flag <= 1'b0;
                    end else begin
                        shadow_min <= sat_step(shadow_min, up_press, down_press);
                    end
                end
                COMMIT: begin
                    // an empty or inverted range is rejected and re-edited
                    if (shadow_max > shadow_min) begin
                        max_val    <= shadow_max;
                        min_val    <= shadow_min;
                        reload_n   <= 1'b0;
                        enable_reg <= 1'b1;
                        error_flag <= 1'b0;
                        cur_state  <= RUN;
                    end else begin
                        error_flag <= 1'b1;
                        cur_state  <= EDIT_MAX;
                    end
                end
                default: begin
                    cur_state <= RUN;
                end
            endcase
        end
    end

    assign bus.cnt_max    = max_val;
    assign bus.cnt_min    = min_val;
    assign bus.cnt_enable = enable_reg;
    assign bus.cnt_rst_n  = reload_n;
    assign bus.cfg_error  = error_flag;
    assign bus.state      = cur_state;
    assign bus.edit_val   = (cur_state == EDIT_MAX) ? shadow_max :
                            (cur_state == EDIT_MIN) ? shadow_min : '0;

endmodule

// File: doc/ppc_config_controller.md
Name: ppc_config_controller

Overview:
Front-panel configuration controller for the ping-pong counter. It conditions three raw push-buttons (mode/up/down) and runs an edit FSM that lets the user change the counter's max and min bounds. It validates the new bounds, commits them, and sequences the counter's enable and reset around each edit. It sits between the board buttons and the counter's max/min/enable/rst_n inputs. The whole block runs in the single clk_origin domain, using a tick enable rather than a derived clock.

Parameters:
TICK_W, 16, width of the free-running tick counter; tick_en pulses once every 2^TICK_W clk_origin cycles (use 2 in simulation).
DEB_LEN, 4, number of consecutive high tick samples required to declare a button pressed.
VAL_W, 4, width of max/min values.

Ports:
clk_origin  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
btn_mode  input  1  raw mode button, active-high.
btn_up  input  1  raw increment button, active-high.
btn_down  input  1  raw decrement button, active-high.
cnt_max  output  VAL_W  committed upper bound to the counter.
cnt_min  output  VAL_W  committed lower bound to the counter.
cnt_enable  output  1  counter enable; high only in RUN.
cnt_rst_n  output  1  active-low one-cycle reload pulse to the counter.
edit_val  output  VAL_W  shadow value currently being edited, for the display; 0 in RUN.
state  output  2  FSM state, for the display and debug.
cfg_error  output  1  sticky flag: last commit was rejected.

Behaviour:
- Reset (async, rst_n=0):
  - tick counter = 0; all debounce shift registers and one-pulse delay flops = 0.
  - state = RUN.
  - cnt_max = 15, cnt_min = 0, shadow_max = 15, shadow_min = 0.
  - cnt_enable = 1, cnt_rst_n = 1, cfg_error = 0, edit_val = 0.
- Tick generation:
  - TICK_W-bit counter increments every cycle and wraps.
  - tick_en = 1 in the cycle the counter equals all-ones.
- Button conditioning, per button:
  - On tick_en, shift the raw input into a DEB_LEN-bit shift register.
  - debounced = all ones.
  - The press pulse is registered: high for exactly one clk_origin cycle, in the cycle after the tick on which debounced goes 0->1.
  - A held button produces one pulse only; releasing it re-arms the button.
- State encoding: RUN=0, EDIT_MAX=1, EDIT_MIN=2, COMMIT=3.
- FSM transitions, on press pulses:
  - RUN + mode: go to EDIT_MAX; copy cnt_max/cnt_min into the shadow registers; cnt_enable drops in the same edge.
  - EDIT_MAX + mode: go to EDIT_MIN.
  - EDIT_MIN + mode: go to COMMIT.
  - COMMIT lasts one cycle, no input needed:
    - If shadow_max > shadow_min: copy the shadows to cnt_max/cnt_min, drive cnt_rst_n = 0 for exactly that one following cycle, clear cfg_error, go to RUN.
    - Otherwise: set cfg_error, leave cnt_* unchanged, go to EDIT_MAX with the shadows kept.
  - Any mode press clears cfg_error.
- Editing:
  - In EDIT_MAX, up/down adjust shadow_max; in EDIT_MIN, they adjust shadow_min.
  - Adjustments are ±1, saturating at 0 and 2^VAL_W-1; no wrap.
  - Up and down in the same cycle: no change.
  - Mode together with up or down in the same cycle: mode wins and the up/down is discarded.
  - Up/down in RUN or COMMIT are ignored.
- Outputs:
  - cnt_enable = (state==RUN), registered together with the state.
  - edit_val = shadow_max in EDIT_MAX, shadow_min in EDIT_MIN, 0 otherwise.
  - cnt_max/cnt_min change only in COMMIT; they are stable at all other times.
- Reset mid-edit: shadow edits are discarded and the block returns to the reset values above.

Decomposition:
- Shared package: state encoding constants RUN/EDIT_MAX/EDIT_MIN/COMMIT, reset defaults MAX_RST=15 and MIN_RST=0, and the VAL_W default.
- Sub-module btn_conditioner(clk_origin, rst_n, tick_en, btn, press): the debounce shift register plus one-pulse flop, parameterised by DEB_LEN and instantiated three times.
- Tick counter and FSM live in the top.

Test Plan:
1. Reset release, TICK_W=2, DEB_LEN=4 -> cnt_max=15, cnt_min=0, cnt_enable=1, cnt_rst_n=1, state=RUN; btn_mode held 20 cycles -> exactly one 1-cycle press pulse, state=EDIT_MAX, cnt_enable=0.
2. Glitch btn_up high for 3 ticks then low, while in EDIT_MAX -> no press pulse, shadow_max unchanged.
3. Edit path: EDIT_MAX, down x6 -> edit_val=9; mode; up x3 -> edit_val=3; mode -> COMMIT, then cnt_max=9, cnt_min=3, cnt_rst_n low exactly 1 cycle, state=RUN, cnt_enable=1.
4. Invalid commit: EDIT_MAX with max set to 2, EDIT_MIN with min set to 5, mode -> cfg_error=1, state=EDIT_MAX, cnt_max/cnt_min still at old values, no cnt_rst_n pulse; next mode press -> cfg_error=0.
5. Saturation: EDIT_MIN at 0, down x3 -> stays 0; EDIT_MAX at 15, up -> stays 15. Up and down pressed on the same tick -> no change.
6. rst_n asserted in EDIT_MIN after edits -> immediately state=RUN, cnt_max=15, cnt_min=0, cnt_enable=1, shadow edits lost.
